// File: rtl/seq_array_divider.sv
// Sequential restoring divider: one shift/compare/subtract step per clock.
// Quotient, remainder and div_by_zero are loaded when a division finishes and hold until the next accept.
module seq_array_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DIVIDEND_W-1:0] acc_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    shifted_d;
  logic                  ge_d;
  logic [DIVISOR_W:0]    prem_d;
  logic [DIVIDEND_W-1:0] acc_d;

  // One restoring step; prem_q < divisor always, so its top bit is zero and may be dropped on shift.
  always_comb begin
    shifted_d = {prem_q[DIVISOR_W-1:0], acc_q[DIVIDEND_W-1]};
    ge_d      = (shifted_d >= {1'b0, dvs_q});
    if (ge_d) begin
      prem_d = shifted_d - {1'b0, dvs_q};
    end else begin
      prem_d = shifted_d;
    end
    acc_d = {acc_q[DIVIDEND_W-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      quot_q  <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend[DIVISOR_W-1:0];
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              acc_q   <= dividend;
              dvs_q   <= divisor;
              prem_q  <= '0;
              cnt_q   <= CNT_W'(DIVIDEND_W);
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_q  <= acc_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            quot_q  <= acc_d;
            rem_q   <= prem_d[DIVISOR_W-1:0];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_array_divider.md
Name: seq_array_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Accepts an unsigned dividend and divisor, and produces quotient and remainder using one shift/subtract step per clock.
- Sits beside the multiplier in the arithmetic datapath. The default widths match the multiplier: its 8-bit product can be fed back as the dividend with a 4-bit divisor.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width in bits; must be >= 2.
- DIVISOR_W, 4, divisor and remainder width in bits; must be >= 2 and <= DIVIDEND_W.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a division; sampled only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend; sampled on the accepting edge.
- divisor  input  DIVISOR_W  unsigned divisor; sampled on the accepting edge.
- busy  output  1  high while a division is in progress (RUN or DONE).
- done  output  1  single-cycle pulse; quotient, remainder and div_by_zero are valid and stable.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  high with done when divisor was 0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Reset values (rst high at a rising edge): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. Reset overrides start and any in-flight operation; the partial result is discarded, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0 (edge E0):
  - Latch dividend into the quotient/shift register and divisor into the divisor register.
  - Clear the partial remainder (DIVISOR_W+1 bits internally), load count=DIVIDEND_W, set div_by_zero=0, go to RUN.
- IDLE, start=1, divisor==0 (edge E0):
  - quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero=1, go to DONE.
- IDLE, start=0: hold state; outputs keep their last values.
- RUN, each edge:
  - Shift {partial_rem, quotient} left by 1; the dividend MSB enters the partial-remainder LSB.
  - If shifted partial_rem >= divisor: subtract the divisor and set quotient LSB=1. Otherwise restore (no subtract) and set quotient LSB=0.
  - Decrement count. The edge that processes count==1 moves to DONE.
- Arithmetic:
  - Comparison and subtraction are DIVISOR_W+1 bits wide, so no overflow is possible.
  - The final partial remainder is always < divisor. remainder = its low DIVISOR_W bits.
- DONE: done=1 for exactly one cycle, busy=1. The next edge goes to IDLE (done=0, busy=0).
- Result hold: quotient, remainder and div_by_zero hold their final values from the DONE cycle until the next accepted start or reset.
- busy=1 in RUN and DONE, 0 in IDLE.
- Latency, normal case: start sampled at E0; done is high in the cycle following edge E0+DIVIDEND_W (8 edges for default widths).
- Latency, divide-by-zero: done is high in the cycle following E0.
- start while busy=1 (RUN or DONE) is ignored and not queued; dividend/divisor changes during RUN have no effect.
- start in the same cycle that done is high is ignored. The earliest accept is the first IDLE cycle.
- Back-to-back operation: new start accepted in IDLE immediately after DONE gives a throughput of one division per DIVIDEND_W+2 cycles.
- Boundaries:
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend=0: quotient=0, remainder=0.
  - divisor=1: quotient=dividend, remainder=0.
  - Maximum operands: no wrap.
- Invariant (checked by verification on every done with div_by_zero=0): quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Basic: dividend=200, divisor=7, start 1 cycle -> done exactly 8 edges after accept, quotient=28, remainder=4, div_by_zero=0, busy high for 9 cycles.
- Extremes: 255/15 -> q=17, r=0. 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0.
- Divide by zero: dividend=100, divisor=0 -> done in cycle after accept, q=0xFF, r=4, div_by_zero=1. Next valid division clears div_by_zero.
- Handshake: pulse start with 50/6 during RUN of 200/7, and again while done=1 -> both ignored, result q=28, r=4. A start held high continuously restarts only on IDLE cycles.
- Reset mid-operation: assert rst at 4th RUN cycle of 200/7 -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent 144/12 -> q=12, r=0.
- Random: 10,000 random operand pairs including 0 divisors, back-to-back starts -> invariant holds, latency always 8 (or 1 for zero divisor), results stable until next accept.
